// File: rtl/i2s_adc_receiver.sv
// i2s_adc_receiver
// Capture side of the WM8731 audio path. Deserializes AUD_ADCDAT in I2S format
// with the codec as bit/frame clock master, and presents each left/right pair
// on a valid/ready port in the Clk domain. All codec pins are synchronized and
// their edges are detected in Clk; Clk must run at least 8x the bit clock.
// Optional feature: define I2S_RX_PEAK_EN to add Peak_out/Peak_clr, a running
// maximum of |Left_out| over presented pairs.
module i2s_adc_receiver #(
  parameter int DATA_W      = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              AUD_BCLK,
  input  logic              AUD_ADCLRCK,
  input  logic              AUD_ADCDAT,
  output logic [DATA_W-1:0] Left_out,
  output logic [DATA_W-1:0] Right_out,
  output logic              Valid,
  input  logic              Ready,
  output logic              Overrun,
  output logic              Frame_err
`ifdef I2S_RX_PEAK_EN
  ,
  output logic [DATA_W-1:0] Peak_out,
  input  logic              Peak_clr
`endif
);

  localparam int CNT_W = $clog2(DATA_W + 1);

  localparam logic [1:0] ST_ALIGN = 2'd0;
  localparam logic [1:0] ST_DELAY = 2'd1;
  localparam logic [1:0] ST_SHIFT = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  // Synchronizer chains, index 0 is the pin side.
  logic [SYNC_STAGES-1:0] bclk_sync_q;
  logic [SYNC_STAGES-1:0] lrck_sync_q;
  logic [SYNC_STAGES-1:0] dat_sync_q;

  logic bclk_s, lrck_s, dat_s;
  logic bclk_prev_q, lrck_prev_q;
  logic bclk_rise_q, lrck_rise_q, lrck_fall_q, dat_q;
  logic lrck_edge;

  logic [1:0]        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-2:0] shift_q, shift_d;
  logic [DATA_W-1:0] word_in;
  logic              chan_q, chan_d;
  logic              left_ok_q, left_ok_d;
  logic [DATA_W-1:0] left_word_q, left_word_d;
  logic [DATA_W-1:0] pair_right_q, pair_right_d;
  logic              pair_q, pair_d;
  logic              frame_err_q, frame_err_d;

  logic [DATA_W-1:0] left_out_q, right_out_q;
  logic              valid_q, overrun_q;

  assign bclk_s = bclk_sync_q[SYNC_STAGES-1];
  assign lrck_s = lrck_sync_q[SYNC_STAGES-1];
  assign dat_s  = dat_sync_q[SYNC_STAGES-1];

  // Bring the three asynchronous codec pins into the Clk domain.
  always_ff @(posedge Clk) begin
    // NOTE: sequential state always uses non-blocking assignment so every flop
    // samples the pre-edge value of its source regardless of block ordering.
    if (Reset) begin
      bclk_sync_q <= '0;
      lrck_sync_q <= '0;
      dat_sync_q  <= '0;
    end else begin
      bclk_sync_q <= {bclk_sync_q[SYNC_STAGES-2:0], AUD_BCLK};
      lrck_sync_q <= {lrck_sync_q[SYNC_STAGES-2:0], AUD_ADCLRCK};
      dat_sync_q  <= {dat_sync_q[SYNC_STAGES-2:0], AUD_ADCDAT};
    end
  end

  // Register edge strobes and the data bit together so they stay aligned.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      bclk_prev_q <= 1'b0;
      lrck_prev_q <= 1'b0;
      bclk_rise_q <= 1'b0;
      lrck_rise_q <= 1'b0;
      lrck_fall_q <= 1'b0;
      dat_q       <= 1'b0;
    end else begin
      bclk_prev_q <= bclk_s;
      lrck_prev_q <= lrck_s;
      bclk_rise_q <= bclk_s & ~bclk_prev_q;
      lrck_rise_q <= lrck_s & ~lrck_prev_q;
      lrck_fall_q <= ~lrck_s & lrck_prev_q;
      dat_q       <= dat_s;
    end
  end

  assign lrck_edge = lrck_rise_q | lrck_fall_q;
  assign word_in   = {shift_q, dat_q};

  // Frame alignment, I2S one-bit delay, shifting and word/pair bookkeeping.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it
    // unassigned; otherwise synthesis would infer a latch.
    state_d      = state_q;
    cnt_d        = cnt_q;
    shift_d      = shift_q;
    chan_d       = chan_q;
    left_ok_d    = left_ok_q;
    left_word_d  = left_word_q;
    pair_right_d = pair_right_q;
    pair_d       = 1'b0;
    frame_err_d  = 1'b0;

    if (state_q == ST_ALIGN) begin
      // Only the start of a left word gives a trustworthy frame boundary.
      if (lrck_fall_q) begin
        state_d   = ST_DELAY;
        cnt_d     = '0;
        chan_d    = 1'b0;
        left_ok_d = 1'b0;
      end
    end else if (lrck_edge) begin
      // A channel boundary before the word filled means the word was cut short.
      if (state_q != ST_DONE) frame_err_d = 1'b1;
      state_d = ST_DELAY;
      cnt_d   = '0;
      chan_d  = lrck_rise_q;
      if (lrck_fall_q) left_ok_d = 1'b0;
    end else if (bclk_rise_q) begin
      if (state_q == ST_DELAY) begin
        state_d = ST_SHIFT;
      end else if (state_q == ST_SHIFT) begin
        shift_d = word_in[DATA_W-2:0];
        cnt_d   = cnt_q + 1'b1;
        if (cnt_d == CNT_W'(DATA_W)) begin
          state_d = ST_DONE;
          if (!chan_q) begin
            left_word_d = word_in;
            left_ok_d   = 1'b1;
          end else if (left_ok_q) begin
            // Right word only forms a pair with a left word from this frame.
            pair_right_d = word_in;
            pair_d       = 1'b1;
            left_ok_d    = 1'b0;
          end
        end
      end
    end
  end

  // Receiver state registers.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q      <= ST_ALIGN;
      cnt_q        <= '0;
      shift_q      <= '0;
      chan_q       <= 1'b0;
      left_ok_q    <= 1'b0;
      left_word_q  <= '0;
      pair_right_q <= '0;
      pair_q       <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      shift_q      <= shift_d;
      chan_q       <= chan_d;
      left_ok_q    <= left_ok_d;
      left_word_q  <= left_word_d;
      pair_right_q <= pair_right_d;
      pair_q       <= pair_d;
      frame_err_q  <= frame_err_d;
    end
  end

  // Output holding register with valid/ready handshake and overrun flag.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      left_out_q  <= '0;
      right_out_q <= '0;
      valid_q     <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      overrun_q <= 1'b0;
      if (pair_q) begin
        // A new pair always wins; it is an overrun only if the old one was
        // neither consumed before nor in this very cycle.
        left_out_q  <= left_word_q;
        right_out_q <= pair_right_q;
        valid_q     <= 1'b1;
        overrun_q   <= valid_q & ~Ready;
      end else if (valid_q && Ready) begin
        valid_q <= 1'b0;
      end
    end
  end

  assign Left_out  = left_out_q;
  assign Right_out = right_out_q;
  assign Valid     = valid_q;
  assign Overrun   = overrun_q;
  assign Frame_err = frame_err_q;

`ifdef I2S_RX_PEAK_EN
  localparam logic [DATA_W-1:0] MOST_NEG = {1'b1, {(DATA_W-1){1'b0}}};
  localparam logic [DATA_W-1:0] MOST_POS = ~MOST_NEG;

  logic              load_q;
  logic [DATA_W-1:0] peak_q;
  logic [DATA_W-1:0] left_mag;

  // Magnitude of the held left sample, saturating the most negative code.
  always_comb begin
    left_mag = left_out_q;
    if (left_out_q == MOST_NEG)  left_mag = MOST_POS;
    else if (left_out_q[DATA_W-1]) left_mag = -left_out_q;
  end

  // Track the running peak one cycle after each output load.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      load_q <= 1'b0;
      peak_q <= '0;
    end else begin
      load_q <= pair_q;
      if (Peak_clr)                          peak_q <= '0;
      else if (load_q && (left_mag > peak_q)) peak_q <= left_mag;
    end
  end

  assign Peak_out = peak_q;
`endif

endmodule

// File: tb/tb_i2s_adc_receiver.sv
// Testbench for i2s_adc_receiver: drives I2S frames generated from sample
// values and slot lengths, and compares presented pairs, error/overrun pulses
// and latency against expectations derived from the frame contents.
module tb_i2s_adc_receiver;

  localparam int DW   = 16;
  localparam int SYNC = 2;

  logic          Clk = 1'b0;
  logic          Reset;
  logic          AUD_BCLK, AUD_ADCLRCK, AUD_ADCDAT;
  logic [DW-1:0] Left_out, Right_out;
  logic          Valid, Ready, Overrun, Frame_err;
`ifdef I2S_RX_PEAK_EN
  logic [DW-1:0] Peak_out;
  logic          Peak_clr;
`endif

  i2s_adc_receiver #(.DATA_W(DW), .SYNC_STAGES(SYNC)) dut (
    .Clk        (Clk),
    .Reset      (Reset),
    .AUD_BCLK   (AUD_BCLK),
    .AUD_ADCLRCK(AUD_ADCLRCK),
    .AUD_ADCDAT (AUD_ADCDAT),
    .Left_out   (Left_out),
    .Right_out  (Right_out),
    .Valid      (Valid),
    .Ready      (Ready),
    .Overrun    (Overrun),
    .Frame_err  (Frame_err)
`ifdef I2S_RX_PEAK_EN
    ,
    .Peak_out   (Peak_out),
    .Peak_clr   (Peak_clr)
`endif
  );

  always #10 Clk = ~Clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic [31:0] got_q[$];
  logic [31:0] exp_q[$];
  int ovr_cnt, ferr_cnt, valid_cycles, valid_low, rise_cyc, lsb_cyc, exp_ferr;
  logic valid_prev = 1'b0;

  always @(posedge Clk) cyc <= cyc + 1;

  // Observe outputs shortly after the falling edge, once inputs have settled.
  always begin
    @(negedge Clk);
    #2;
    if (Valid && Ready) got_q.push_back({Left_out, Right_out});
    if (Valid) valid_cycles++;
    else       valid_low++;
    if (Valid && !valid_prev) rise_cyc = cyc;
    if (Overrun)   ovr_cnt++;
    if (Frame_err) ferr_cnt++;
    valid_prev = Valid;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge Clk);
  endtask

  task automatic clear_obs();
    got_q.delete();
    exp_q.delete();
    ovr_cnt = 0; ferr_cnt = 0; valid_cycles = 0; valid_low = 0;
    rise_cyc = -1; exp_ferr = 0;
  endtask

  task automatic check_pairs(input string tag);
    int n;
    check({tag, "_count"}, got_q.size(), exp_q.size());
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++)
      check($sformatf("%s_pair%0d", tag, i), got_q[i], exp_q[i]);
  endtask

  // One I2S frame: left slot of lbits BCLKs, right slot of rbits BCLKs.
  // Bit 0 of each slot is the I2S delay bit, bits 1..DW carry the word MSB
  // first, later bits are padding. Data and LRCK change on the BCLK fall.
  task automatic send_frame(input logic [DW-1:0] l, input logic [DW-1:0] r,
                            input int lbits, input int rbits, input int half,
                            input int rst_bit, input bit pulse_ready);
    int nb;
    logic [DW-1:0] w;
    for (int ch = 0; ch < 2; ch++) begin
      nb = (ch == 1) ? rbits : lbits;
      w  = (ch == 1) ? r : l;
      for (int i = 0; i < nb; i++) begin
        AUD_BCLK = 1'b0;
        if (i == 0) AUD_ADCLRCK = (ch == 1);
        AUD_ADCDAT = (i >= 1 && i <= DW) ? w[DW-i] : 1'($urandom);
        if (ch == 1 && i == rst_bit) begin
          Reset = 1'b1;
          idle(2);
          Reset = 1'b0;
          idle(half - 2);
        end else begin
          idle(half);
        end
        AUD_BCLK = 1'b1;
        if (ch == 1 && i == DW) begin
          lsb_cyc = cyc;
          if (pulse_ready) begin
            // Raise Ready only for the cycle in which the new pair loads.
            idle(SYNC + 2);
            Ready = 1'b1;
            idle(1);
            Ready = 1'b0;
            idle(half - SYNC - 3);
          end else begin
            idle(half);
          end
        end else begin
          idle(half);
        end
      end
    end
  endtask

`ifdef I2S_RX_PEAK_EN
  function automatic logic [DW-1:0] mag(input logic [DW-1:0] v);
    int s;
    s = int'(signed'(v));
    if (s < 0) s = -s;
    if (s > 32767) s = 32767;
    return 16'(s);
  endfunction
`endif

  initial begin
    logic [DW-1:0] l, r;
    int lb, rb, hb;
`ifdef I2S_RX_PEAK_EN
    logic [DW-1:0] peak_model;
    Peak_clr = 1'b0;
`endif
    Reset = 1'b1; AUD_BCLK = 1'b0; AUD_ADCLRCK = 1'b1; AUD_ADCDAT = 1'b0; Ready = 1'b1;
    clear_obs();
    idle(4);
    check("rst_valid", Valid, 0);
    check("rst_left", Left_out, 0);
    check("rst_right", Right_out, 0);
    check("rst_overrun", Overrun, 0);
    check("rst_frame_err", Frame_err, 0);
`ifdef I2S_RX_PEAK_EN
    check("rst_peak", Peak_out, 0);
`endif
    Reset = 1'b0;
    idle(10);

    // Basic frame with Ready held high: one pair, single-cycle Valid.
    clear_obs();
    send_frame(16'h1234, 16'hABCD, 32, 32, 8, -1, 1'b0);
    idle(20);
    exp_q.push_back(32'h1234ABCD);
    check_pairs("basic");
    check("basic_valid_cycles", valid_cycles, 1);
    check("basic_latency", rise_cyc - lsb_cyc - 1, SYNC + 2);
    check("basic_ferr", ferr_cnt, 0);

    // Reset mid right word drops that pair; the next frame is received.
    clear_obs();
    send_frame(16'h5555, 16'h6666, 32, 32, 8, 8, 1'b0);
    send_frame(16'h8000, 16'h7FFF, 32, 32, 8, -1, 1'b0);
    idle(20);
    exp_q.push_back(32'h80007FFF);
    check_pairs("rst_mid");
    check("rst_mid_ferr", ferr_cnt, 0);

    // Ready low over two frames: second pair overwrites with one Overrun.
    clear_obs();
    Ready = 1'b0;
    send_frame(16'h0111, 16'h0222, 32, 32, 8, -1, 1'b0);
    check("hold1_valid", Valid, 1);
    check("hold1_data", {Left_out, Right_out}, 32'h01110222);
    check("hold1_ovr", ovr_cnt, 0);
    valid_low = 0;
    send_frame(16'h0333, 16'h0444, 32, 32, 8, -1, 1'b0);
    check("hold2_valid", Valid, 1);
    check("hold2_data", {Left_out, Right_out}, 32'h03330444);
    check("hold2_ovr", ovr_cnt, 1);

    // Ready only in the completion cycle: old pair consumed, new pair held.
    send_frame(16'h0555, 16'h0666, 32, 32, 10, -1, 1'b1);
    exp_q.push_back(32'h03330444);
    check_pairs("same_cycle");
    check("same_cycle_valid", Valid, 1);
    check("same_cycle_data", {Left_out, Right_out}, 32'h05550666);
    check("same_cycle_ovr", ovr_cnt, 1);
    check("hold_valid_low", valid_low, 0);
    got_q.delete(); exp_q.delete();
    Ready = 1'b1;
    idle(4);
    exp_q.push_back(32'h05550666);
    check_pairs("drain");

    // Short left slots (10 and DW BCLKs) error out; a minimum slot passes.
    clear_obs();
    send_frame(16'h0AAA, 16'h0BBB, 10, 32, 6, -1, 1'b0);
    send_frame(16'h0CCC, 16'h0DDD, DW, 32, 6, -1, 1'b0);
    send_frame(16'hFEDC, 16'h0123, DW + 1, DW + 1, 6, -1, 1'b0);
    send_frame(16'h4321, 16'h8765, 32, 32, 6, -1, 1'b0);
    idle(20);
    exp_q.push_back(32'hFEDC0123);
    exp_q.push_back(32'h43218765);
    check_pairs("short");
    check("short_ferr", ferr_cnt, 2);

`ifdef I2S_RX_PEAK_EN
    // Peak tracking of |Left_out| with saturation and clear.
    Peak_clr = 1'b1; idle(1); Peak_clr = 1'b0; idle(1);
    check("peak_clr0", Peak_out, 16'h0000);
    send_frame(16'hFFF0, 16'h1111, 32, 32, 6, -1, 1'b0); idle(10);
    check("peak_fff0", Peak_out, 16'h0010);
    send_frame(16'h0100, 16'h2222, 32, 32, 6, -1, 1'b0); idle(10);
    check("peak_0100", Peak_out, 16'h0100);
    send_frame(16'h8000, 16'h3333, 32, 32, 6, -1, 1'b0); idle(10);
    check("peak_8000", Peak_out, 16'h7FFF);
    Peak_clr = 1'b1; idle(1); Peak_clr = 1'b0; idle(1);
    check("peak_clr", Peak_out, 16'h0000);
    peak_model = '0;
`endif

    // Randomized frames: varied samples, slot lengths and bit clock rates.
    clear_obs();
    for (int f = 0; f < 14; f++) begin
      l  = 16'($urandom);
      r  = 16'($urandom);
      lb = ($urandom_range(0, 4) == 0) ? $urandom_range(10, DW) : $urandom_range(DW + 1, 24);
      rb = $urandom_range(DW + 1, 24);
      hb = $urandom_range(4, 9);
      send_frame(l, r, lb, rb, hb, -1, 1'b0);
      if (lb >= DW + 1) begin
        exp_q.push_back({l, r});
`ifdef I2S_RX_PEAK_EN
        if (mag(l) > peak_model) peak_model = mag(l);
`endif
      end else begin
        exp_ferr++;
      end
    end
    idle(20);
    check_pairs("rand");
    check("rand_ferr", ferr_cnt, exp_ferr);
    check("rand_ovr", ovr_cnt, 0);
`ifdef I2S_RX_PEAK_EN
    check("rand_peak", Peak_out, peak_model);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
